// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_OUT
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port and
// one combinational read port. Out-of-range read addresses return zero.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // Write port: store the incoming payload byte at its slot.
  // NOTE: the array has no reset; stale contents are never read because the
  // parser only releases slots it wrote in the current frame. Non-blocking
  // assignments keep every register update on the same clock edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && waddr == IDX_W'(i)) mem[i] <= wdata;
    end
  end

  // Read port: decode the address against every entry.
  // NOTE: rdata gets a default before the loop so no latch is inferred.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == IDX_W'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SOF/LEN/payload/CHK frames from a byte stream, validates the XOR
// checksum and releases good payloads on an AXI-Stream byte master.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       drop_pulse,
  output logic       busy
);

  localparam int         IDX_W     = $clog2(MAX_LEN + 1);
  localparam int         TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t             state, state_n;
  logic [IDX_W-1:0]   len, len_n;
  logic [IDX_W-1:0]   wr_idx, wr_idx_n;
  logic [IDX_W-1:0]   rd_idx, rd_idx_n;
  logic [7:0]         chk, chk_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
  logic               ok_n, err_n, drop_n;
  logic [1:0]         code_n;
  logic               buf_we;
  logic [7:0]         buf_rdata;

  uart_frame_buf #(
    .DEPTH(MAX_LEN),
    .IDX_W(IDX_W)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(wr_idx),
    .wdata(s_axis_tdata),
    .raddr(rd_idx),
    .rdata(buf_rdata)
  );

  // Output stream is driven straight from the state and read index so that a
  // stalled beat stays stable until accepted; data is zero outside OUT.
  assign m_axis_tvalid = (state == ST_OUT);
  assign m_axis_tdata  = m_axis_tvalid ? buf_rdata : 8'h00;
  assign m_axis_tlast  = m_axis_tvalid && (rd_idx == len - IDX_W'(1));
  assign busy          = (state != ST_IDLE);

  // Next-state, datapath and pulse decode for the frame FSM.
  always_comb begin
    state_n   = state;
    len_n     = len;
    wr_idx_n  = wr_idx;
    rd_idx_n  = rd_idx;
    chk_n     = chk;
    tmo_cnt_n = '0;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    code_n    = 2'd0;
    drop_n    = 1'b0;
    buf_we    = 1'b0;

    // An idle cycle inside a frame advances the timeout; a byte always wins.
    if (state inside {ST_LEN, ST_PAYLOAD, ST_CHK} && !s_axis_tvalid) begin
      if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_n = ST_IDLE;
        err_n   = 1'b1;
        code_n  = ERR_TMO;
      end else begin
        tmo_cnt_n = tmo_cnt + TMO_W'(1);
      end
    end

    case (state)
      ST_IDLE: begin
        if (s_axis_tvalid && s_axis_tdata == SOF_BYTE) state_n = ST_LEN;
      end
      ST_LEN: begin
        if (s_axis_tvalid) begin
          if (s_axis_tdata == 8'h00 || s_axis_tdata > MAX_LEN_B) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_LEN;
          end else begin
            len_n    = s_axis_tdata[IDX_W-1:0];
            chk_n    = s_axis_tdata;
            wr_idx_n = '0;
            state_n  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (s_axis_tvalid) begin
          buf_we   = 1'b1;
          chk_n    = chk ^ s_axis_tdata;
          wr_idx_n = wr_idx + IDX_W'(1);
          if (wr_idx + IDX_W'(1) == len) state_n = ST_CHK;
        end
      end
      ST_CHK: begin
        if (s_axis_tvalid) begin
          if (s_axis_tdata == chk) begin
            ok_n     = 1'b1;
            rd_idx_n = '0;
            state_n  = ST_OUT;
          end else begin
            err_n   = 1'b1;
            code_n  = ERR_CHK;
            state_n = ST_IDLE;
          end
        end
      end
      ST_OUT: begin
        drop_n = s_axis_tvalid;
        if (m_axis_tready) begin
          if (m_axis_tlast) begin
            rd_idx_n = '0;
            state_n  = ST_IDLE;
          end else begin
            rd_idx_n = rd_idx + IDX_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counters, checksum and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len        <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      chk        <= '0;
      tmo_cnt    <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      wr_idx     <= wr_idx_n;
      rd_idx     <= rd_idx_n;
      chk        <= chk_n;
      tmo_cnt    <= tmo_cnt_n;
      frame_ok   <= ok_n;
      frame_err  <= err_n;
      err_code   <= code_n;
      drop_pulse <= drop_n;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: the stimulus pushes expected beats
// and status pulses, a negedge monitor pops and compares them.
module tb_uart_frame_parser;
  import uart_frame_pkg::*;

  localparam int TMO = 10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       drop_pulse;
  logic       busy;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN(16),
    .SOF_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_code     (err_code),
    .drop_pulse   (drop_pulse),
    .busy         (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         drop_cnt = 0;
  logic       toggle_en = 1'b0;
  logic [8:0] beat_q [$];   // {tlast, tdata}
  logic [2:0] pulse_q [$];  // {frame_ok, err_code}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("drain_done", {31'd0, busy}, 32'd0);
  endtask

  // Downstream ready: steady high, or toggling every cycle when enabled.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = toggle_en ? ~m_axis_tready : 1'b1;
    end
  end

  // Monitor: compares accepted beats and status pulses against the queues.
  logic       stall_prev = 1'b0;
  logic [8:0] stall_val;
  always @(negedge clk) begin
    logic [9:0] exp_beat;
    logic [3:0] exp_pulse;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold_stable", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {22'd0, 1'b1, stall_val});
      if (m_axis_tvalid && m_axis_tready) begin
        exp_beat = (beat_q.size() > 0) ? {1'b0, beat_q.pop_front()} : 10'h200;
        check("beat", {22'd0, 1'b0, m_axis_tlast, m_axis_tdata}, {22'd0, exp_beat});
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_val  = {m_axis_tlast, m_axis_tdata};
      if (frame_ok || frame_err) begin
        check("ok_err_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
        exp_pulse = (pulse_q.size() > 0) ? {1'b0, pulse_q.pop_front()} : 4'h8;
        check("status_pulse", {28'd0, 1'b0, frame_ok, err_code}, {28'd0, exp_pulse});
      end
      if (drop_pulse) drop_cnt++;
    end
  end

  initial begin
    int n;
    int k;
    int d0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("reset_outputs",
          {16'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_ok, frame_err, err_code, drop_pulse, busy},
          32'd0);
    rst_n = 1'b1;

    // Good frame with tready high
    beat_q.push_back({1'b0, 8'h11});
    beat_q.push_back({1'b0, 8'h22});
    beat_q.push_back({1'b1, 8'h33});
    pulse_q.push_back(3'b100);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    send(8'h03);
    check("tvalid_before_chk", {31'd0, m_axis_tvalid}, 32'd0);
    idle();
    check("tvalid_latency", {31'd0, m_axis_tvalid}, 32'd1);
    wait_drain(n);
    check("drain_cycles", n, 3);
    check("no_drop_good", drop_cnt, 0);

    // Bad checksum
    pulse_q.push_back({1'b0, ERR_CHK});
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    idle();
    check("badchk_no_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    repeat (3) @(negedge clk);
    check("badchk_not_busy", {31'd0, busy}, 32'd0);

    // Bad lengths, then a one-byte frame
    pulse_q.push_back({1'b0, ERR_LEN});
    send(8'hA5); send(8'h00); idle();
    repeat (2) @(negedge clk);
    check("len0_not_busy", {31'd0, busy}, 32'd0);
    pulse_q.push_back({1'b0, ERR_LEN});
    send(8'hA5); send(8'h11); idle();
    repeat (2) @(negedge clk);
    check("len17_not_busy", {31'd0, busy}, 32'd0);
    beat_q.push_back({1'b1, 8'h7E});
    pulse_q.push_back(3'b100);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F); idle();
    wait_drain(n);

    // Timeout after the first payload byte
    pulse_q.push_back({1'b0, ERR_TMO});
    send(8'hA5); send(8'h02); send(8'h11);
    idle();
    for (k = 1; k <= TMO + 10; k++) begin
      @(posedge clk); #1;
      if (frame_err) break;
    end
    check("timeout_cycles", k, TMO);
    @(negedge clk);
    check("timeout_not_busy", {31'd0, busy}, 32'd0);
    beat_q.push_back({1'b0, 8'h12});
    beat_q.push_back({1'b1, 8'h34});
    pulse_q.push_back(3'b100);
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h24); idle();
    wait_drain(n);

    // Backpressure plus two bytes arriving during the drain
    toggle_en = 1'b1;
    d0 = drop_cnt;
    beat_q.push_back({1'b0, 8'hAA});
    beat_q.push_back({1'b1, 8'hBB});
    pulse_q.push_back(3'b100);
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
    send(8'h01); send(8'h02); idle();
    wait_drain(n);
    check("drop_count", drop_cnt - d0, 2);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);

    // Async reset in the middle of a payload
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02); idle();
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_midframe",
          {16'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_ok, frame_err, err_code, drop_pulse, busy},
          32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    beat_q.push_back({1'b1, 8'h55});
    pulse_q.push_back(3'b100);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h54); idle();
    wait_drain(n);

    repeat (5) @(negedge clk);
    check("beat_q_empty", beat_q.size(), 0);
    check("pulse_q_empty", pulse_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
